player_vertical: RTL

Per-frame vertical physics for the runner character: integrates height and velocity and owns the ground/air/duck state machine. Sits directly downstream of the speed-parameter lookup and consumes its `gravity`, `duck_limit` and `vertical_jump` outputs each game frame. Feeds height and duck status to the renderer and the collision checker.

---
 rtl/player_vertical.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/player_vertical.sv
// ---------------------------------------------------------------------------
// player_vertical
//
// Per-frame vertical physics for the runner character. Integrates height and
// velocity once per game frame and owns the ground / air / duck / halt state
// machine. Jump and duck requests can arrive on any cycle. They are remembered
// until the next frame tick so that a press between frames is not lost.
//
// Ports
//   clk_in         system clock
//   rst_in         asynchronous active-low reset
//   frame_tick     one-cycle pulse per game frame; physics advances only here
//   jump_req       jump request pulse (any cycle)
//   duck_req       duck request pulse (any cycle)
//   game_over      level; forces HALT, which is left only through reset
//   gravity        unsigned per-tick velocity decrement
//   duck_limit     unsigned duck duration in ticks (0 behaves as 1)
//   vertical_jump  unsigned takeoff velocity, also the fast-fall speed
//   height         unsigned feet height above ground, subunits
//   velocity       signed vertical velocity, subunits per tick
//   state          0 GROUND, 1 AIR, 2 DUCK, 3 HALT
//   ducking        high iff state is DUCK
//   airborne       high iff state is AIR
// ---------------------------------------------------------------------------
module player_vertical (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick,
    input  logic        jump_req,
    input  logic        duck_req,
    input  logic        game_over,
    input  logic [3:0]  gravity,
    input  logic [7:0]  duck_limit,
    input  logic [9:0]  vertical_jump,
    output logic [15:0] height,
    output logic [11:0] velocity,
    output logic [1:0]  state,
    output logic        ducking,
    output logic        airborne
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        DUCK   = 2'd2,
        HALT   = 2'd3
    } phase_t;

    phase_t cur_state;
    phase_t next_state;

    logic        jump_pend;
    logic        duck_pend;
    logic        land_duck;
    logic        land_duck_next;
    logic [7:0]  duck_count;
    logic [7:0]  duck_count_next;
    logic [15:0] height_next;
    logic [11:0] velocity_next;
    logic        ducking_next;
    logic        airborne_next;

    logic        jump_eff;
    logic        duck_eff;
    logic        tick_live;
    logic        landed;
    logic        duck_done;
    logic [8:0]  duck_limit_eff;
    logic [15:0] height_air;
    logic [11:0] velocity_air;

    logic signed [17:0] takeoff_vel;
    logic signed [17:0] v_eff;
    logic signed [17:0] h_sum;
    logic signed [17:0] v_dec;

    // A request arriving in the same cycle as the tick counts for that tick,
    // so the live pulse is OR-ed with the remembered one.
    assign jump_eff  = jump_req | jump_pend;
    assign duck_eff  = duck_req | duck_pend;
    assign tick_live = frame_tick & ~game_over;

    // Airborne integration is done at 18 signed bits, so neither the
    // landing test nor the ceiling clip can be fooled by a 16-bit wrap.
    // A duck in the air replaces the current velocity with a fast fall.
    assign takeoff_vel  = $signed({8'd0, vertical_jump});
    assign v_eff        = duck_eff ? -takeoff_vel
                                   : $signed({{6{velocity[11]}}, velocity});
    assign h_sum        = $signed({2'b00, height}) + v_eff;
    assign v_dec        = v_eff - $signed({14'd0, gravity});
    assign landed       = (h_sum <= 18'sd0);
    assign height_air   = (h_sum > 18'sd65535) ? 16'hFFFF : h_sum[15:0];
    assign velocity_air = (v_dec < -18'sd1023) ? 12'hC01 : v_dec[11:0];

    // A zero duck limit still gives one tick of duck.
    assign duck_limit_eff = (duck_limit == 8'd0) ? 9'd1 : {1'b0, duck_limit};
    assign duck_done      = (({1'b0, duck_count} + 9'd1) >= duck_limit_eff);

    assign state = cur_state;

    // State and datapath registers. Reset drops everything back to standing
    // on the ground, whatever the character was doing.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cur_state  <= GROUND;
            height     <= 16'd0;
            velocity   <= 12'd0;
            duck_count <= 8'd0;
            land_duck  <= 1'b0;
            ducking    <= 1'b0;
            airborne   <= 1'b0;
        end else begin
            cur_state  <= next_state;
            height     <= height_next;
            velocity   <= velocity_next;
            duck_count <= duck_count_next;
            land_duck  <= land_duck_next;
            ducking    <= ducking_next;
            airborne   <= airborne_next;
        end
    end

    // Pending requests live only until the next frame tick. They are also
    // dropped whenever the game is (or is becoming) halted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            jump_pend <= 1'b0;
            duck_pend <= 1'b0;
        end else if (frame_tick || game_over || cur_state == HALT) begin
            jump_pend <= 1'b0;
            duck_pend <= 1'b0;
        end else begin
            jump_pend <= jump_pend | jump_req;
            duck_pend <= duck_pend | duck_req;
        end
    end

    // Next-state logic. game_over wins over any tick in the same cycle, and
    // jump wins over duck everywhere except in the air, where jump is ignored.
    always_comb begin
        next_state = cur_state;
        if (game_over) begin
            next_state = HALT;
        end else if (frame_tick) begin
            case (cur_state)
                GROUND: begin
                    if (jump_eff) begin
                        next_state = AIR;
                    end else if (duck_eff) begin
                        next_state = DUCK;
                    end
                end
                AIR: begin
                    if (landed) begin
                        next_state = (land_duck | duck_eff) ? DUCK : GROUND;
                    end
                end
                DUCK: begin
                    if (jump_eff) begin
                        next_state = AIR;
                    end else if (duck_eff) begin
                        next_state = DUCK;
                    end else if (duck_done) begin
                        next_state = GROUND;
                    end
                end
                default: next_state = HALT;
            endcase
        end
    end

    // Datapath and status updates. Everything holds unless a live tick
    // arrives. A fast fall is remembered in land_duck so the landing drops
    // straight into a duck.
    always_comb begin
        height_next     = height;
        velocity_next   = velocity;
        duck_count_next = duck_count;
        land_duck_next  = land_duck;
        if (tick_live) begin
            case (cur_state)
                GROUND: begin
                    if (jump_eff) begin
                        velocity_next = {2'b00, vertical_jump};
                    end else if (duck_eff) begin
                        duck_count_next = 8'd0;
                    end
                end
                AIR: begin
                    if (landed) begin
                        height_next     = 16'd0;
                        velocity_next   = 12'd0;
                        duck_count_next = 8'd0;
                        land_duck_next  = 1'b0;
                    end else begin
                        height_next    = height_air;
                        velocity_next  = velocity_air;
                        land_duck_next = land_duck | duck_eff;
                    end
                end
                DUCK: begin
                    if (jump_eff) begin
                        velocity_next   = {2'b00, vertical_jump};
                        duck_count_next = 8'd0;
                        land_duck_next  = 1'b0;
                    end else if (duck_eff || duck_done) begin
                        duck_count_next = 8'd0;
                    end else begin
                        duck_count_next = duck_count + 8'd1;
                    end
                end
                default: begin
                    height_next = height;
                end
            endcase
        end
        ducking_next  = (next_state == DUCK);
        airborne_next = (next_state == AIR);
    end

endmodule
